// File: rtl/ram_burst_pkg.sv
// Shared types and default sizes for the RAM burst controller.
// Optional feature macro used by ram_burst_ctrl: BOUNDS_CHECK_EN.
package ram_burst_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Command field widths at the default geometry.
    localparam int CMD_DIR_W  = 1;
    localparam int CMD_ADDR_W = DEF_N;
    localparam int CMD_LEN_W  = DEF_N;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAPT  = 3'd3,
        RD_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst controller and sole master of a single-port RAM with a one-cycle registered read.
// Define BOUNDS_CHECK_EN to reject bursts that would run past the top address (err pulse).
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_len,
    input  logic         wd_valid,
    output logic         wd_ready,
    input  logic [W-1:0] wd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic         done,
    output logic         busy,
    output logic         err,
    output logic         ram_wr_rd,
    output logic         ram_valid,
    output logic [N-1:0] ram_addr,
    output logic [W-1:0] ram_wdata,
    input  logic [W-1:0] ram_rdata,
    input  logic         ram_ready
);

    // All streams use valid/ready: a beat transfers on a rising edge where both are high;
    // ready is driven from state only, never from the matching valid.

    localparam logic [N-1:0] ONE = N'(1);

    state_t       state_q, state_d;
    logic [N-1:0] cur_addr_q, cur_addr_d;
    logic [N-1:0] beats_left_q, beats_left_d;
    logic [W-1:0] rd_data_q, rd_data_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         last_beat;
    logic         cmd_bad;

    assign last_beat = (beats_left_q == '0);

`ifdef BOUNDS_CHECK_EN
    logic [N:0] end_addr;
    assign end_addr = {1'b0, req_addr} + {1'b0, req_len};
    assign cmd_bad  = end_addr[N];
`else
    assign cmd_bad  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // A rejected command is still consumed so the requester never stalls on it.
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        cur_addr_d   = req_addr;
                        beats_left_d = req_len;
                        state_d      = req_wr ? WRITE : RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                if (wd_valid) begin
                    cur_addr_d   = cur_addr_q + ONE;
                    beats_left_d = beats_left_q - ONE;
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                // The read stays on the RAM port until the registered data is flagged ready.
                if (ram_ready) begin
                    rd_data_d = ram_rdata;
                    state_d   = RD_OUT;
                end
            end
            RD_OUT: begin
                if (rd_ready) begin
                    cur_addr_d   = cur_addr_q + ONE;
                    beats_left_d = beats_left_q - ONE;
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        ram_valid = 1'b0;
        ram_wr_rd = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE: req_ready = rst;
            WRITE: begin
                wd_ready  = 1'b1;
                ram_valid = wd_valid;
                ram_wr_rd = 1'b1;
                ram_addr  = cur_addr_q;
                ram_wdata = wd_data;
            end
            RD_ISSUE, RD_CAPT: begin
                ram_valid = 1'b1;
                ram_addr  = cur_addr_q;
            end
            default: ;
        endcase
    end

    assign rd_valid = (state_q == RD_OUT);
    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule
